// File: rtl/mr_pkg.sv
// mr_pkg: shared types and constants for the instruction fetch stage.
//   XLEN, IMAXLEN   address and instruction widths
//   ifetch_state_e  fetch FSM states (IF_IDLE, IF_REQ, IF_DRAIN)
//   IF_ENTRY_W      width of one prefetch FIFO entry {fault?, pc, inst}
//   pc_align()      clears PC bits [1:0]
// Optional feature macro: MR_IFETCH_FAULT_EN adds a fault bit to each entry.
package mr_pkg;

  localparam int XLEN    = 32;
  localparam int IMAXLEN = 32;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_DRAIN = 2'd2
  } ifetch_state_e;

`ifdef MR_IFETCH_FAULT_EN
  localparam int IF_FAULT_W = 1;
`else
  localparam int IF_FAULT_W = 0;
`endif

  localparam int IF_ENTRY_W = XLEN + IMAXLEN + IF_FAULT_W;

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return a & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mr_sync_fifo.sv
// mr_sync_fifo: small synchronous FIFO with flush, reusable outside the fetch stage.
// Ports:
//   clk        clock
//   rst        synchronous active-low reset (0 = reset)
//   i_push     write i_wdata (ignored when full, unless a pop frees the slot this cycle)
//   i_pop      drop head entry (ignored when empty)
//   i_flush    empty the FIFO; wins over push and pop
//   i_wdata    entry to write
//   o_count    number of stored entries (0..DEPTH)
//   o_empty    no entries stored
//   o_head     entry at the head (meaningful only when !o_empty)
// DEPTH need not be a power of two: pointers wrap explicitly at DEPTH-1.
module mr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic [WIDTH-1:0]           o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (rst && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/mr_ifetch.sv
// mr_ifetch: instruction fetch stage.
// Owns the fetch PC, reads 32-bit words over a req/ack imem bus into a prefetch
// FIFO, and presents them to decode with a valid/ready handshake.
// Ports:
//   clk, rst                   clock; synchronous active-low reset (0 = reset)
//   imem_req / imem_addr       registered bus request; held stable until imem_ack
//   imem_ack / imem_rdata      read completion and data (ack ignored while imem_req=0)
//   imem_err                   bus error qualifying ack (MR_IFETCH_FAULT_EN only)
//   inst / inst_pc             FIFO head instruction and its PC
//   inst_valid / inst_ready    decode handshake; an entry pops when both are 1
//   inst_fault                 head entry carries a bus error (MR_IFETCH_FAULT_EN only)
//   redirect_valid/redirect_pc one-cycle restart request; target bits [1:0] cleared
//   o_dbg_state                current fetch FSM state (ifetch_state_e encoding)
// Optional feature macro: MR_IFETCH_FAULT_EN.
//
// Handshakes: a decode transfer happens on a clock edge where inst_valid and
// inst_ready are both 1; a bus transfer happens on an edge where imem_req and
// imem_ack are both 1. Once raised, imem_req/imem_addr do not change until that
// transfer completes, even across a redirect.
module mr_ifetch
  import mr_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [IMAXLEN-1:0] imem_rdata,
`ifdef MR_IFETCH_FAULT_EN
  input  logic               imem_err,
  output logic               inst_fault,
`endif
  output logic [IMAXLEN-1:0] inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [1:0]         o_dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  ifetch_state_e         r_state;
  logic                  r_imem_req;
  logic [XLEN-1:0]       r_imem_addr;
  logic [XLEN-1:0]       r_fetch_pc;
  logic                  r_stopped;

  logic [CNT_W-1:0]      w_cnt;
  logic [CNT_W-1:0]      w_cnt_after_pop;
  logic                  w_empty;
  logic [IF_ENTRY_W-1:0] w_head;
  logic [IF_ENTRY_W-1:0] w_push_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_err;
  logic                  w_room_now;
  logic                  w_room_after_push;
  logic [XLEN-1:0]       w_target;
  logic [XLEN-1:0]       w_pc_inc;

  assign w_target = pc_align(redirect_pc);
  assign w_pc_inc = r_fetch_pc + XLEN'(4);

  // A redirect flushes the FIFO, so neither the coincident ack nor pop may act.
  assign w_push = (r_state == IF_REQ) && imem_ack && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  // Free-slot tests account for this cycle's pop so a full FIFO being drained
  // still sustains one fetch per cycle.
  assign w_cnt_after_pop   = w_cnt - CNT_W'(w_pop);
  assign w_room_now        = int'(w_cnt_after_pop) < FIFO_DEPTH;
  assign w_room_after_push = (int'(w_cnt_after_pop) + 1) < FIFO_DEPTH;

`ifdef MR_IFETCH_FAULT_EN
  assign w_err       = imem_err;
  assign w_push_data = {w_err, r_imem_addr, (w_err ? '0 : imem_rdata)};
  assign inst_fault  = !w_empty && w_head[IF_ENTRY_W-1];
`else
  assign w_err       = 1'b0;
  assign w_push_data = {r_imem_addr, imem_rdata};
`endif

  mr_sync_fifo #(
    .WIDTH (IF_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_push_data),
    .o_count (w_cnt),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Fetch FSM. In IF_REQ imem_addr equals r_fetch_pc; in IF_DRAIN r_fetch_pc
  // holds the redirect target while the abandoned request completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IF_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
      r_stopped   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_stopped  <= 1'b0;
      if ((r_state != IF_IDLE) && !imem_ack) begin
        // Bus still owes an ack for the old address; wait it out.
        r_state <= IF_DRAIN;
      end else begin
        r_state     <= IF_REQ;
        r_imem_req  <= 1'b1;
        r_imem_addr <= w_target;
      end
    end else begin
      case (r_state)
        IF_IDLE: begin
          if (!r_stopped && w_room_now) begin
            r_state     <= IF_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
          end
        end
        IF_REQ: begin
          if (imem_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_err) begin
              r_state    <= IF_IDLE;
              r_imem_req <= 1'b0;
              r_stopped  <= 1'b1;
            end else if (w_room_after_push) begin
              r_imem_addr <= w_pc_inc;
            end else begin
              r_state    <= IF_IDLE;
              r_imem_req <= 1'b0;
            end
          end
        end
        IF_DRAIN: begin
          if (imem_ack) begin
            r_state     <= IF_REQ;
            r_imem_addr <= r_fetch_pc;
          end
        end
        default: begin
          r_state    <= IF_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign inst_valid  = !w_empty;
  assign inst_pc     = w_head[IMAXLEN +: XLEN];
  assign inst        = w_head[0 +: IMAXLEN];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mr_ifetch.sv
// Bench for mr_ifetch: directed scenarios followed by a randomized run.
// The bench acts as instruction memory (word content is a fixed hash of the
// address, with configurable ack latency) and as decode. The reference model is
// the architectural rule: decode sees consecutive word PCs starting at RESET_PC
// or at the latest redirect target, each carrying the memory word at that PC.
module tb_mr_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
`ifdef MR_IFETCH_FAULT_EN
    logic        imem_err;
    logic        inst_fault;
`endif
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;

    mr_ifetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
`ifdef MR_IFETCH_FAULT_EN
        .imem_err       (imem_err),
        .inst_fault     (inst_fault),
`endif
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- bench state ----------------
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    logic        rst_val;
    int          mem_lat;
    int          mem_wait;
    bit          mem_rand_lat;
    bit          err_en;
    logic [31:0] err_addr;
    logic        prev_req;
    logic        prev_ack;
    logic        prev_rst;
    logic [31:0] prev_addr;
    logic [31:0] old_addr;
    int          n;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pc + 32'(4 * i));
        end
    endtask

    task automatic sb_pop();
        logic [31:0] exp_pc;
        while (exp_q.size() < 4) begin
            exp_q.push_back(exp_q[$] + 32'd4);
        end
        exp_pc = exp_q.pop_front();
        pops++;
        chk("pop_pc", inst_pc, exp_pc);
`ifdef MR_IFETCH_FAULT_EN
        if (err_en && (exp_pc == err_addr)) begin
            chk("pop_fault", 32'(inst_fault), 32'd1);
            chk("pop_inst_faulted", inst, 32'd0);
        end else begin
            chk("pop_fault", 32'(inst_fault), 32'd0);
            chk("pop_inst", inst, mem_word(exp_pc));
        end
`else
        chk("pop_inst", inst, mem_word(exp_pc));
`endif
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Inputs change at the falling edge; outputs are inspected at the falling
    // edge (pop / bus checks) and 1 time unit after the rising edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rst            = rst_val;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;

        if (prev_req && !prev_ack && prev_rst) begin
            chk("bus_req_held", 32'(imem_req), 32'd1);
            chk("bus_addr_held", imem_addr, prev_addr);
        end

        // memory responder
`ifdef MR_IFETCH_FAULT_EN
        imem_err = 1'b0;
`endif
        if (imem_req) begin
            if (mem_wait >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
`ifdef MR_IFETCH_FAULT_EN
                imem_err   = err_en && (imem_addr == err_addr);
`endif
                mem_wait   = 0;
                if (mem_rand_lat) begin
                    mem_lat = $urandom_range(0, 3);
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_wait++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            mem_wait   = 0;
        end

        if (!rst_val) begin
            sb_restart(RESET_PC);
        end else if (redir) begin
            sb_restart(rpc & 32'hFFFF_FFFC);
        end else if (inst_valid && rdy) begin
            sb_pop();
        end

        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
        prev_rst  = rst_val;

        @(posedge clk);
        #1;
        if (redir && rst_val) begin
            chk("redirect_flush", 32'(inst_valid), 32'd0);
        end
    endtask

    // Advance (decode ready) until the outstanding request has seen exactly w
    // wait cycles; a bounded search whose expiry is itself a failed check.
    task automatic wait_req_wait(input int w, input string tag);
        int k = 0;
        while (!(imem_req && (mem_wait == w)) && (k < 40)) begin
            cycle(1'b1, 1'b0, 32'd0);
            k++;
        end
        chk(tag, 32'(imem_req && (mem_wait == w)), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!inst_valid && (k < 20)) begin
            cycle(1'b1, 1'b0, 32'd0);
            k++;
        end
        chk(tag, 32'(inst_valid), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_val        = 1'b0;
        rst            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
`ifdef MR_IFETCH_FAULT_EN
        imem_err       = 1'b0;
`endif
        mem_lat        = 0;
        mem_wait       = 0;
        mem_rand_lat   = 1'b0;
        err_en         = 1'b0;
        err_addr       = 32'd0;
        prev_req       = 1'b0;
        prev_ack       = 1'b0;
        prev_rst       = 1'b0;
        prev_addr      = 32'd0;
        sb_restart(RESET_PC);

        // Reset state
        repeat (3) cycle(1'b0, 1'b0, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(inst_valid), 32'd0);

        // Zero-wait memory, decode always ready: one instruction per cycle
        rst_val = 1'b1;
        cycle(1'b1, 1'b0, 32'd0);
        chk("a_req_after_release", 32'(imem_req), 32'd1);
        chk("a_first_addr", imem_addr, RESET_PC);
        chk("a_valid_before_ack", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        chk("a_first_valid", 32'(inst_valid), 32'd1);
        chk("a_first_pc", inst_pc, RESET_PC);
        for (int k = 1; k < 8; k++) begin
            cycle(1'b1, 1'b0, 32'd0);
            chk("a_stream_valid", 32'(inst_valid), 32'd1);
            chk("a_stream_pc", inst_pc, RESET_PC + 32'(4 * k));
        end

        // Backpressure: FIFO fills to two entries and the bus goes quiet
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 32'd0);
        end
        chk("b_req_dropped", 32'(imem_req), 32'd0);
        chk("b_valid_held", 32'(inst_valid), 32'd1);
        chk("b_head_pc", inst_pc, RESET_PC + 32'd28);
        cycle(1'b1, 1'b0, 32'd0);
        chk("b_req_resumed", 32'(imem_req), 32'd1);
        chk("b_second_buffered", inst_pc, RESET_PC + 32'd32);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // 3-cycle ack latency, redirect in the first wait cycle
        mem_lat = 3;
        wait_req_wait(0, "c_find_new_req");
        old_addr = imem_addr;
        cycle(1'b1, 1'b1, 32'h0000_0100);
        chk("c_addr_held", imem_addr, old_addr);
        chk("c_req_held", 32'(imem_req), 32'd1);
        n = 0;
        while ((imem_addr != 32'h0000_0100) && (n < 10)) begin
            cycle(1'b1, 1'b0, 32'd0);
            chk("c_stale_dropped", 32'(inst_valid), 32'd0);
            n++;
        end
        chk("c_new_addr", imem_addr, 32'h0000_0100);
        wait_valid("c_valid_timeout");
        chk("c_first_pc", inst_pc, 32'h0000_0100);
        repeat (3) cycle(1'b1, 1'b0, 32'd0);

        // Redirect coincident with ack and pop; target low bits are dropped
        mem_lat = 0;
        repeat (4) cycle(1'b1, 1'b0, 32'd0);
        chk("d_pre_valid", 32'(inst_valid), 32'd1);
        chk("d_pre_req", 32'(imem_req), 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_0202);
        chk("d_addr", imem_addr, 32'h0000_0200);
        chk("d_req", 32'(imem_req), 32'd1);
        wait_valid("d_valid_timeout");
        chk("d_first_pc", inst_pc, 32'h0000_0200);
        repeat (3) cycle(1'b1, 1'b0, 32'd0);

        // PC wrap-around at the top of the address space
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (8) cycle(1'b1, 1'b0, 32'd0);
        chk("g_wrap_head", inst_pc, 32'hFFFF_FFF8 + 32'd28);

        // Reset while a request is pending, with the ack landing during reset
        mem_lat = 3;
        wait_req_wait(3, "e_find_ack_cycle");
        rst_val = 1'b0;
        cycle(1'b1, 1'b0, 32'd0);
        chk("e_req", 32'(imem_req), 32'd0);
        chk("e_valid", 32'(inst_valid), 32'd0);
        chk("e_addr", imem_addr, RESET_PC);
        repeat (2) cycle(1'b1, 1'b0, 32'd0);
        mem_lat = 0;
        rst_val = 1'b1;
        cycle(1'b1, 1'b0, 32'd0);
        chk("e_req_after_release", 32'(imem_req), 32'd1);
        chk("e_addr_after_release", imem_addr, RESET_PC);
        cycle(1'b1, 1'b0, 32'd0);
        chk("e_restart_pc", inst_pc, RESET_PC);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

`ifdef MR_IFETCH_FAULT_EN
        // Bus error at pc 8 stops fetch until the next redirect
        err_en   = 1'b1;
        err_addr = 32'h0000_0008;
        cycle(1'b1, 1'b1, 32'h0000_0000);
        repeat (3) cycle(1'b1, 1'b0, 32'd0);
        chk("f_head_fault", 32'(inst_fault), 32'd1);
        chk("f_head_pc", inst_pc, 32'h0000_0008);
        chk("f_req_stopped", 32'(imem_req), 32'd0);
        repeat (5) cycle(1'b1, 1'b0, 32'd0);
        chk("f_still_stopped", 32'(imem_req), 32'd0);
        chk("f_fifo_empty", 32'(inst_valid), 32'd0);
        err_en = 1'b0;
        cycle(1'b1, 1'b1, 32'h0000_0040);
        chk("f_resume_req", 32'(imem_req), 32'd1);
        chk("f_resume_addr", imem_addr, 32'h0000_0040);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);
`endif

        // Randomized traffic: latency, decode stalls and redirects
        mem_rand_lat = 1'b1;
        pops = 0;
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), $urandom);
        end
        mem_rand_lat = 1'b0;
        chk("r_progress", 32'(pops > 50), 32'd1);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
